mem_fill_arbiter: RTL and testbench

- Arbitrates the single shared unified main-memory port between the I-cache miss path and the D-cache (miss fills and write-through stores) of the 16-bit pipelined CPU.
- Sequences each 16-byte block fill as 8 back-to-back word reads and steers the returned words to the owning cache.
- Single-beat stores pass straight through.
- Sits between the cache controllers and the multi-cycle memory model; the CPU top instantiates it once.

---
 rtl/mem_fill_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter
//   Shares the single main-memory port between the I-cache miss path and the
//   D-cache (miss fills and write-through stores). A block fill is issued as
//   BLK_WORDS back-to-back word reads; returned words are steered to the cache
//   that owns the fill. Stores go out as one write beat.
//
//   Optional feature macro: ARB_RR_EN
//     defined   : alternate D/I miss grants when both are pending (D first)
//     undefined : fixed D-over-I miss priority
//   dc_wr always has top priority.
//
//   Ports
//     clk, rst                     clock, synchronous active-high reset
//     ic_miss/ic_miss_addr         I-side level miss request + byte address
//     ic_fill_valid/_word/_done    I-side fill word strobe, index, last word
//     dc_miss/dc_miss_addr         D-side level miss request + byte address
//     dc_fill_valid/_word/_done    D-side fill word strobe, index, last word
//     dc_wr/dc_wr_addr/dc_wr_data  D-side level store request
//     dc_wr_ack                    store issued this cycle
//     fill_data                    returned word, shared, qualified by *_fill_valid
//     mem_en/mem_wr/mem_addr/mem_wdata  memory request
//     mem_rdata/mem_rvalid         in-order read return
//     busy                         not idle
//     err                          sticky watchdog / stray-return error
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | arbitrate dc_wr > dc_miss > ic_miss
//   S_WRITE | one store beat on the memory port
//   S_FILL  | issue one read per cycle, accept returns
//   S_DRAIN | all reads issued, wait for the remaining returns
//   S_DONE  | one dead cycle so the requester can drop its request
module mem_fill_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8,
  parameter int MAX_LAT   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ic_miss,
  input  logic [ADDR_W-1:0]            ic_miss_addr,
  output logic                         ic_fill_valid,
  output logic [$clog2(BLK_WORDS)-1:0] ic_fill_word,
  output logic                         ic_fill_done,
  input  logic                         dc_miss,
  input  logic [ADDR_W-1:0]            dc_miss_addr,
  output logic                         dc_fill_valid,
  output logic [$clog2(BLK_WORDS)-1:0] dc_fill_word,
  output logic                         dc_fill_done,
  input  logic                         dc_wr,
  input  logic [ADDR_W-1:0]            dc_wr_addr,
  input  logic [DATA_W-1:0]            dc_wr_data,
  output logic                         dc_wr_ack,
  output logic [DATA_W-1:0]            fill_data,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_rvalid,
  output logic                         busy,
  output logic                         err
);

  localparam int WORD_W = $clog2(BLK_WORDS);
  localparam int WD_W   = $clog2(MAX_LAT + 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLK_WORDS - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(MAX_LAT - 1);
  // Clears the byte offset within a block (2 bytes per word).
  localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'(2 * BLK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_FILL, S_DRAIN, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                owner_dc_q, owner_dc_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [WORD_W-1:0]   issue_q, issue_d;
  logic [WORD_W-1:0]   ret_q, ret_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                err_q, err_d;
`ifdef ARB_RR_EN
  logic                last_i_q, last_i_d;
`endif

  logic accepting, rx, last_ret, grant_dc;

  assign accepting = (state_q == S_FILL) || (state_q == S_DRAIN);
  assign rx        = mem_rvalid && accepting;
  assign last_ret  = rx && (ret_q == LAST_WORD);

  always_comb begin
    state_d    = state_q;
    owner_dc_d = owner_dc_q;
    base_d     = base_q;
    issue_d    = issue_q;
    ret_d      = ret_q;
    wd_d       = wd_q;
    err_d      = err_q;
    grant_dc   = 1'b0;
`ifdef ARB_RR_EN
    last_i_d   = last_i_q;
`endif
    // A return with no read outstanding means the memory side is confused.
    if (mem_rvalid && !accepting) err_d = 1'b1;
    if (rx) ret_d = ret_q + WORD_W'(1);

    case (state_q)
      S_IDLE: begin
        issue_d = '0;
        ret_d   = '0;
        wd_d    = '0;
`ifdef ARB_RR_EN
        grant_dc = dc_miss && (!ic_miss || last_i_q);
`else
        grant_dc = dc_miss;
`endif
        if (dc_wr) begin
          state_d = S_WRITE;
        end else if (dc_miss || ic_miss) begin
          state_d    = S_FILL;
          owner_dc_d = grant_dc;
          base_d     = (grant_dc ? dc_miss_addr : ic_miss_addr) & BLK_MASK;
`ifdef ARB_RR_EN
          last_i_d   = !grant_dc;
`endif
        end
      end
      S_WRITE: state_d = S_DONE;
      S_FILL: begin
        issue_d = issue_q + WORD_W'(1);
        if (last_ret)                    state_d = S_DONE;
        else if (issue_q == LAST_WORD)   state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // The final return wins over a watchdog expiring in the same cycle.
        if (last_ret) begin
          state_d = S_DONE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ic_fill_valid = rx && !owner_dc_q;
    dc_fill_valid = rx && owner_dc_q;
    ic_fill_word  = ic_fill_valid ? ret_q : '0;
    dc_fill_word  = dc_fill_valid ? ret_q : '0;
    ic_fill_done  = last_ret && !owner_dc_q;
    dc_fill_done  = last_ret && owner_dc_q;
    fill_data     = rx ? mem_rdata : '0;
    mem_en        = (state_q == S_WRITE) || (state_q == S_FILL);
    mem_wr        = (state_q == S_WRITE);
    dc_wr_ack     = (state_q == S_WRITE);
    mem_wdata     = (state_q == S_WRITE) ? dc_wr_data : '0;
    mem_addr      = '0;
    // OR rather than add: the word offset never carries out of the block.
    if (state_q == S_WRITE)     mem_addr = dc_wr_addr;
    else if (state_q == S_FILL) mem_addr = base_q | ADDR_W'({issue_q, 1'b0});
    busy          = (state_q != S_IDLE);
    err           = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_dc_q <= 1'b0;
      base_q     <= '0;
      issue_q    <= '0;
      ret_q      <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
`ifdef ARB_RR_EN
      last_i_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      owner_dc_q <= owner_dc_d;
      base_q     <= base_d;
      issue_q    <= issue_d;
      ret_q      <= ret_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
`ifdef ARB_RR_EN
      last_i_q   <= last_i_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Testbench for mem_fill_arbiter: directed and randomized request mixes
// against a grant-order / access-log reference model and a latency-programmable
// memory responder.
module tb_mem_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_miss = 1'b0, dc_miss = 1'b0, dc_wr = 1'b0;
  logic [15:0] ic_miss_addr = '0, dc_miss_addr = '0, dc_wr_addr = '0, dc_wr_data = '0;
  logic        ic_fill_valid, ic_fill_done, dc_fill_valid, dc_fill_done, dc_wr_ack;
  logic [2:0]  ic_fill_word, dc_fill_word;
  logic [15:0] fill_data, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_en, mem_wr, busy, err;

  mem_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
    .ic_fill_valid(ic_fill_valid), .ic_fill_word(ic_fill_word), .ic_fill_done(ic_fill_done),
    .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
    .dc_fill_valid(dc_fill_valid), .dc_fill_word(dc_fill_word), .dc_fill_done(dc_fill_done),
    .dc_wr(dc_wr), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data), .dc_wr_ack(dc_wr_ack),
    .fill_data(fill_data), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory responder: read issued in cycle k returns in cycle k+lat.
  int  lat = 4;
  int  ret_limit = 8;
  bit  stray_req = 1'b0;
  int  cyc = 0;
  int  reads_seen = 0;
  logic [15:0] mem [0:32767];
  typedef struct { int due; logic [15:0] data; } rd_t;
  rd_t pend[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rst) begin
      pend.delete();
      reads_seen = 0;
    end else begin
      if (!busy) reads_seen = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend[0].data;
        void'(pend.pop_front());
      end else if (stray_req) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h1111;
        stray_req  = 1'b0;
      end
      if (mem_en && !mem_wr) begin
        if (reads_seen < ret_limit) pend.push_back('{cyc + lat, mem[mem_addr[15:1]]});
        reads_seen++;
      end
    end
  end

  // Observation logs: {wr, addr, wdata} per access, {side, word, data, done} per return.
  logic [32:0] acc_q[$], exp_acc[$];
  logic [20:0] ev_q[$],  exp_ev[$];
  int busy_cycles = 0, ack_cnt = 0, viol = 0;

  always @(negedge clk) begin
    if (mem_en) acc_q.push_back({mem_wr, mem_addr, mem_wr ? mem_wdata : 16'h0});
    if (ic_fill_valid) ev_q.push_back({1'b0, ic_fill_word, fill_data, ic_fill_done});
    if (dc_fill_valid) ev_q.push_back({1'b1, dc_fill_word, fill_data, dc_fill_done});
    if (busy) busy_cycles++;
    if (dc_wr_ack) ack_cnt++;
    if ((!mem_en && (mem_addr != 16'h0 || mem_wdata != 16'h0)) ||
        (ic_fill_valid && dc_fill_valid) ||
        (ic_fill_done && !ic_fill_valid) || (dc_fill_done && !dc_fill_valid))
      viol++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: D-side flag "I served last" resets to 1, so D wins the first tie.
  bit m_last_i = 1'b1;

  task automatic build_expect(input int dn, input int in, input bit we,
                              input logic [15:0] da, input logic [15:0] ia,
                              input logic [15:0] wa, input logic [15:0] wdat);
    logic [15:0] a, base, wad;
    bit pd;
    exp_acc.delete();
    exp_ev.delete();
    if (we) exp_acc.push_back({1'b1, wa, wdat});
    while (dn > 0 || in > 0) begin
`ifdef ARB_RR_EN
      pd = (dn > 0) && (in == 0 || m_last_i);
`else
      pd = (dn > 0);
`endif
      a    = pd ? da : ia;
      base = a & 16'hFFF0;
      for (int i = 0; i < 8; i++) begin
        wad = base + 16'(2 * i);
        exp_acc.push_back({1'b0, wad, 16'h0});
        exp_ev.push_back({pd, 3'(i), mem[wad[15:1]], (i == 7)});
      end
      m_last_i = !pd;
      if (pd) dn--; else in--;
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    ev_q.delete();
    busy_cycles = 0;
    ack_cnt = 0;
    viol = 0;
  endtask

  task automatic check_logs(input string tag);
    chk({tag, " acc count"}, 64'(acc_q.size()), 64'(exp_acc.size()));
    for (int i = 0; i < exp_acc.size() && i < acc_q.size(); i++)
      chk($sformatf("%s acc[%0d]", tag, i), 64'(acc_q[i]), 64'(exp_acc[i]));
    chk({tag, " ret count"}, 64'(ev_q.size()), 64'(exp_ev.size()));
    for (int i = 0; i < exp_ev.size() && i < ev_q.size(); i++)
      chk($sformatf("%s ret[%0d]", tag, i), 64'(ev_q[i]), 64'(exp_ev[i]));
    chk({tag, " protocol"}, 64'(viol), 64'd0);
  endtask

  // Requester behaviour: hold each level request until its completion, then drop it.
  task automatic serve(input string tag, input int dn, input int in, input bit we,
                       input logic [15:0] da, input logic [15:0] ia,
                       input logic [15:0] wa, input logic [15:0] wdat);
    bit done;
    dc_miss_addr = da;
    ic_miss_addr = ia;
    dc_wr_addr   = wa;
    dc_wr_data   = wdat;
    dc_miss = (dn > 0);
    ic_miss = (in > 0);
    dc_wr   = we;
    done    = 1'b0;
    for (int t = 0; t < 600 && !done; t++) begin
      @(negedge clk);
      if (dc_wr_ack) dc_wr = 1'b0;
      if (dc_fill_done) begin dn--; if (dn <= 0) dc_miss = 1'b0; end
      if (ic_fill_done) begin in--; if (in <= 0) ic_miss = 1'b0; end
      if (!dc_wr && !dc_miss && !ic_miss && !busy) done = 1'b1;
    end
    chk({tag, " completes"}, 64'(done), 64'd1);
    if (!done) begin dc_wr = 1'b0; dc_miss = 1'b0; ic_miss = 1'b0; end
  endtask

  task automatic run(input string tag, input int dn, input int in, input bit we,
                     input logic [15:0] da, input logic [15:0] ia,
                     input logic [15:0] wa, input logic [15:0] wdat);
    build_expect(dn, in, we, da, ia, wa, wdat);
    clear_logs();
    serve(tag, dn, in, we, da, ia, wa, wdat);
    check_logs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dc_miss = 1'b0; ic_miss = 1'b0; dc_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_last_i = 1'b1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ic_fill_valid, ic_fill_word, ic_fill_done, dc_fill_valid, dc_fill_word,
                dc_fill_done, dc_wr_ack, fill_data, mem_en, mem_wr, mem_addr, mem_wdata,
                busy, err});
  endfunction

  initial begin
    int k, n;
    bit seen;
    int dn, in;
    bit we;
    int dones;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);

    do_reset();
    chk("reset outputs", all_outs(), 64'd0);

    lat = 4;
    run("i_miss_0046", 0, 1, 1'b0, 16'h0, 16'h0046, 16'h0, 16'h0);
    chk("i_miss_0046 busy cycles", 64'(busy_cycles), 64'd13);
    chk("i_miss_0046 no ack", 64'(ack_cnt), 64'd0);

    run("wr_then_i", 0, 1, 1'b1, 16'h0, 16'h0300, 16'h1234, 16'hBEEF);
    chk("wr_then_i ack pulses", 64'(ack_cnt), 64'd1);

    do_reset();
    run("both_x2", 2, 2, 1'b0, 16'h0A10, 16'h0B26, 16'h0, 16'h0);

    lat = 6;
    run("top_block", 1, 0, 1'b0, 16'hFFFA, 16'h0, 16'h0, 16'h0);
    if (acc_q.size() > 0)
      chk("top_block last addr", 64'(acc_q[acc_q.size()-1][31:16]), 64'h0000_FFFE);

    // Reset after three returns, then a clean restart from word 0.
    lat = 2;
    ic_miss_addr = 16'h2226;
    ic_miss = 1'b1;
    k = 0;
    for (int t = 0; t < 60 && k < 3; t++) begin
      @(negedge clk);
      if (ic_fill_valid) k++;
    end
    chk("mid_rst returns before reset", 64'(k), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst outputs", all_outs(), 64'd0);
    rst = 1'b0;
    m_last_i = 1'b1;
    run("after_rst", 0, 1, 1'b0, 16'h0, 16'h2226, 16'h0, 16'h0);

    // Watchdog: only six of eight reads come back.
    do_reset();
    clear_logs();
    lat = 3;
    ret_limit = 6;
    ic_miss_addr = 16'h0100;
    ic_miss = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int t = 0; t < 80 && !seen; t++) begin
      @(negedge clk);
      if (err) seen = 1'b1;
      else if (busy && !mem_en) n++;
    end
    chk("wdog err raised", 64'(seen), 64'd1);
    chk("wdog drain cycles", 64'(n), 64'd8);
    ic_miss = 1'b0;
    @(negedge clk);
    chk("wdog back to idle", 64'(busy), 64'd0);
    chk("wdog err sticky", 64'(err), 64'd1);
    chk("wdog returns seen", 64'(ev_q.size()), 64'd6);
    dones = 0;
    foreach (ev_q[i]) if (ev_q[i][0]) dones++;
    chk("wdog no fill_done", 64'(dones), 64'd0);
    ret_limit = 8;

    // Return with nothing outstanding.
    do_reset();
    clear_logs();
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray err", 64'(err), 64'd1);
    chk("stray no fill", 64'(ev_q.size()), 64'd0);
    chk("stray idle", 64'(busy), 64'd0);

    do_reset();
    for (int it = 0; it < 24; it++) begin
      lat = $urandom_range(1, 8);
      dn  = $urandom_range(0, 2);
      in  = $urandom_range(0, 2);
      we  = 1'($urandom_range(0, 1));
      if (dn == 0 && in == 0 && !we) in = 1;
      run($sformatf("rnd%0d", it), dn, in, we, 16'($urandom), 16'($urandom),
          16'($urandom), 16'($urandom));
    end
    chk("rnd no err", 64'(err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
